// File: rtl/trap_controller_if.sv
// Signal bundle between the pipeline/CSR unit and trap_controller.
// The master side drives requests and CSR values; the slave side is the controller.
interface trap_controller_if;
  logic        if_exc_valid_i;
  logic        id_exc_valid_i;
  logic        mem_exc_valid_i;
  logic [3:0]  if_exc_cause_i;
  logic [3:0]  id_exc_cause_i;
  logic [3:0]  mem_exc_cause_i;
  logic [31:0] if_pc_i;
  logic [31:0] id_pc_i;
  logic [31:0] mem_pc_i;
  logic        mret_req_i;
  logic        irq_ext_i;
  logic        irq_soft_i;
  logic        irq_timer_i;
  logic        mstatus_mie_i;
  logic [31:0] mie_i;
  logic        irq_pc_valid_i;
  logic [31:0] irq_pc_i;
  logic [31:0] trap_vector_i;
  logic [31:0] mepc_i;
  logic        exception_o;
  logic [31:0] exception_pc_o;
  logic [31:0] exception_cause_o;
  logic        mret_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport master (
    output if_exc_valid_i, id_exc_valid_i, mem_exc_valid_i,
    output if_exc_cause_i, id_exc_cause_i, mem_exc_cause_i,
    output if_pc_i, id_pc_i, mem_pc_i, mret_req_i,
    output irq_ext_i, irq_soft_i, irq_timer_i, mstatus_mie_i, mie_i,
    output irq_pc_valid_i, irq_pc_i, trap_vector_i, mepc_i,
    input  exception_o, exception_pc_o, exception_cause_o, mret_o,
    input  flush_o, redirect_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  if_exc_valid_i, id_exc_valid_i, mem_exc_valid_i,
    input  if_exc_cause_i, id_exc_cause_i, mem_exc_cause_i,
    input  if_pc_i, id_pc_i, mem_pc_i, mret_req_i,
    input  irq_ext_i, irq_soft_i, irq_timer_i, mstatus_mie_i, mie_i,
    input  irq_pc_valid_i, irq_pc_i, trap_vector_i, mepc_i,
    output exception_o, exception_pc_o, exception_cause_o, mret_o,
    output flush_o, redirect_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/trap_controller.sv
// Trap/return sequencer: arbitrates exceptions, mret and interrupts in IDLE,
// drives the CSR unit for one cycle, drains the pipeline, then redirects fetch.
module trap_controller #(
  parameter int FLUSH_CYCLES = 2
) (
  input logic               clk_i,
  input logic               rst_n_i,
  trap_controller_if.slave  bus
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, TRAP, MRET, DRAIN, REDIRECT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          is_trap, is_trap_next;
  logic [31:0]   pc_next, cause_next, rpc_next;
  logic          irq_ok, ext_win, soft_win, timer_win;
  logic          unused_mie;

  assign irq_ok    = bus.mstatus_mie_i & bus.irq_pc_valid_i;
  assign ext_win   = irq_ok & bus.irq_ext_i   & bus.mie_i[11];
  assign soft_win  = irq_ok & bus.irq_soft_i  & bus.mie_i[3];
  assign timer_win = irq_ok & bus.irq_timer_i & bus.mie_i[7];
  assign unused_mie = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4], bus.mie_i[2:0]};

  // Next-state, drain counter and data latching; requests only matter in IDLE.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    is_trap_next = is_trap;
    pc_next      = bus.exception_pc_o;
    cause_next   = bus.exception_cause_o;
    rpc_next     = bus.redirect_pc_o;
    case (state)
      IDLE: begin
        if (bus.mem_exc_valid_i) begin
          state_next = TRAP; is_trap_next = 1'b1;
          pc_next = bus.mem_pc_i; cause_next = {28'b0, bus.mem_exc_cause_i};
        end else if (bus.id_exc_valid_i) begin
          state_next = TRAP; is_trap_next = 1'b1;
          pc_next = bus.id_pc_i; cause_next = {28'b0, bus.id_exc_cause_i};
        end else if (bus.if_exc_valid_i) begin
          state_next = TRAP; is_trap_next = 1'b1;
          pc_next = bus.if_pc_i; cause_next = {28'b0, bus.if_exc_cause_i};
        end else if (bus.mret_req_i) begin
          state_next = MRET; is_trap_next = 1'b0;
        end else if (ext_win | soft_win | timer_win) begin
          state_next = TRAP; is_trap_next = 1'b1;
          pc_next = bus.irq_pc_i;
          if (ext_win)       cause_next = {1'b1, 27'b0, 4'd11};
          else if (soft_win) cause_next = {1'b1, 27'b0, 4'd3};
          else               cause_next = {1'b1, 27'b0, 4'd7};
        end
      end
      TRAP, MRET: begin
        state_next = DRAIN;
        cnt_next   = CW'(FLUSH_CYCLES - 1);
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_next = REDIRECT;
          rpc_next   = is_trap ? bus.trap_vector_i : bus.mepc_i;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State, counter and registered outputs; strobes are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state                 <= IDLE;
      cnt                   <= '0;
      is_trap               <= 1'b0;
      bus.exception_o       <= 1'b0;
      bus.mret_o            <= 1'b0;
      bus.flush_o           <= 1'b0;
      bus.busy_o            <= 1'b0;
      bus.redirect_o        <= 1'b0;
      bus.exception_pc_o    <= '0;
      bus.exception_cause_o <= '0;
      bus.redirect_pc_o     <= '0;
    end else begin
      state                 <= state_next;
      cnt                   <= cnt_next;
      is_trap               <= is_trap_next;
      bus.exception_o       <= (state_next == TRAP);
      bus.mret_o            <= (state_next == MRET);
      bus.flush_o           <= (state_next != IDLE);
      bus.busy_o            <= (state_next != IDLE);
      bus.redirect_o        <= (state_next == REDIRECT);
      bus.exception_pc_o    <= pc_next;
      bus.exception_cause_o <= cause_next;
      bus.redirect_pc_o     <= rpc_next;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: three instances (FLUSH_CYCLES 2, 1, 4)
// share stimulus; expected events and busy windows are queued per instance.
module tb_trap_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_v, id_v, mem_v, mret_req, irq_ext, irq_soft, irq_timer, mie_g, irq_pc_v;
  logic [3:0]  if_c, id_c, mem_c;
  logic [31:0] if_pc, id_pc, mem_pc, mie, irq_pc, tvec, mepc;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 trap, 1 mret, 2 redirect
    logic [31:0] pc;
    logic [31:0] cause;
    int          at;
  } ev_t;

  ev_t  exp_q [3][$];
  bit   exp_busy [3][512];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  logic [7:0] outs [3];

  function automatic int fc(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  task automatic pop_cmp(input int g, input ev_t got);
    ev_t w;
    checks++;
    if (exp_q[g].size() == 0) begin
      failures++;
      $display("FAIL event dut%0d: got kind=%0d pc=%h cause=%h cyc=%0d, required none",
               g, got.kind, got.pc, got.cause, got.at);
    end else begin
      w = exp_q[g].pop_front();
      if (got.kind != w.kind || got.pc !== w.pc || got.cause !== w.cause || got.at != w.at) begin
        failures++;
        $display("FAIL event dut%0d: got kind=%0d pc=%h cause=%h cyc=%0d, required kind=%0d pc=%h cause=%h cyc=%0d",
                 g, got.kind, got.pc, got.cause, got.at, w.kind, w.pc, w.cause, w.at);
      end
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    trap_controller_if bus();
    assign bus.if_exc_valid_i  = if_v;
    assign bus.id_exc_valid_i  = id_v;
    assign bus.mem_exc_valid_i = mem_v;
    assign bus.if_exc_cause_i  = if_c;
    assign bus.id_exc_cause_i  = id_c;
    assign bus.mem_exc_cause_i = mem_c;
    assign bus.if_pc_i         = if_pc;
    assign bus.id_pc_i         = id_pc;
    assign bus.mem_pc_i        = mem_pc;
    assign bus.mret_req_i      = mret_req;
    assign bus.irq_ext_i       = irq_ext;
    assign bus.irq_soft_i      = irq_soft;
    assign bus.irq_timer_i     = irq_timer;
    assign bus.mstatus_mie_i   = mie_g;
    assign bus.mie_i           = mie;
    assign bus.irq_pc_valid_i  = irq_pc_v;
    assign bus.irq_pc_i        = irq_pc;
    assign bus.trap_vector_i   = tvec;
    assign bus.mepc_i          = mepc;

    trap_controller #(.FLUSH_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 4))) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
    );

    assign outs[g] = {bus.exception_o, bus.mret_o, bus.flush_o, bus.redirect_o, bus.busy_o,
                      |bus.exception_pc_o, |bus.exception_cause_o, |bus.redirect_pc_o};

    // Monitor: busy/flush window every cycle, and every strobe against the queue.
    always @(negedge clk) begin
      bit  eb;
      ev_t ev;
      if (mon_en) begin
        eb = (cyc < 512) ? exp_busy[g][cyc] : 1'b0;
        checks++;
        if (bus.busy_o !== eb) begin
          failures++;
          $display("FAIL busy dut%0d cyc=%0d: got %b required %b", g, cyc, bus.busy_o, eb);
        end
        checks++;
        if (bus.flush_o !== eb) begin
          failures++;
          $display("FAIL flush dut%0d cyc=%0d: got %b required %b", g, cyc, bus.flush_o, eb);
        end
        if (bus.exception_o !== 1'b0) begin
          ev.kind = 0; ev.pc = bus.exception_pc_o; ev.cause = bus.exception_cause_o; ev.at = cyc;
          pop_cmp(g, ev);
        end
        if (bus.mret_o !== 1'b0) begin
          ev.kind = 1; ev.pc = '0; ev.cause = '0; ev.at = cyc;
          pop_cmp(g, ev);
        end
        if (bus.redirect_o !== 1'b0) begin
          ev.kind = 2; ev.pc = bus.redirect_pc_o; ev.cause = '0; ev.at = cyc;
          pop_cmp(g, ev);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    if_v = 0; id_v = 0; mem_v = 0; if_c = '0; id_c = '0; mem_c = '0;
    if_pc = '0; id_pc = '0; mem_pc = '0; mret_req = 0;
    irq_ext = 0; irq_soft = 0; irq_timer = 0; mie_g = 0; mie = '0;
    irq_pc_v = 0; irq_pc = '0;
  endtask

  // c is the IDLE cycle in which the request is detected.
  task automatic expect_seq(input int g, input int c, input int kind, input logic [31:0] pc,
                            input logic [31:0] cause, input logic [31:0] rpc, input bit redir);
    ev_t e;
    int  f;
    int  last;
    f = fc(g);
    e.kind = kind; e.pc = pc; e.cause = cause; e.at = c + 1;
    exp_q[g].push_back(e);
    if (redir) begin
      e.kind = 2; e.pc = rpc; e.cause = '0; e.at = c + 2 + f;
      exp_q[g].push_back(e);
    end
    last = redir ? c + 2 + f : c + 2;
    for (int k = c + 1; k <= last; k++)
      if (k < 512) exp_busy[g][k] = 1'b1;
  endtask

  task automatic expect_all(input int c, input int kind, input logic [31:0] pc,
                            input logic [31:0] cause, input logic [31:0] rpc);
    for (int g = 0; g < 3; g++) expect_seq(g, c, kind, pc, cause, rpc, 1'b1);
  endtask

  task automatic chk_zero(input string name);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (outs[g] !== 8'h00) begin
        failures++;
        $display("FAIL %s dut%0d: outputs %b required 00000000", name, g, outs[g]);
      end
    end
  endtask

  initial begin
    int c0;
    clr();
    rst_n = 1'b0;
    tvec  = 32'h0000_0200;
    mepc  = 32'h0000_0000;
    tick(3);
    chk_zero("reset_state");
    mon_en = 1'b1;
    rst_n  = 1'b1;
    tick(2);

    // MEM exception
    c0 = cyc;
    mem_v = 1; mem_c = 4'd4; mem_pc = 32'h0000_0100;
    expect_all(c0, 0, 32'h0000_0100, 32'h0000_0004, 32'h0000_0200);
    tick(1); clr(); tick(16);

    // Same-cycle IF/ID/MEM: MEM wins
    tvec = 32'h0000_0300;
    c0 = cyc;
    if_v = 1; if_c = 4'd1; if_pc = 32'h10;
    id_v = 1; id_c = 4'd2; id_pc = 32'h0C;
    mem_v = 1; mem_c = 4'd6; mem_pc = 32'h08;
    expect_all(c0, 0, 32'h08, 32'h6, 32'h0000_0300);
    tick(1); clr(); tick(16);

    // IF and ID: ID wins
    c0 = cyc;
    if_v = 1; if_c = 4'd1; if_pc = 32'h10;
    id_v = 1; id_c = 4'd2; id_pc = 32'h0C;
    expect_all(c0, 0, 32'h0C, 32'h2, 32'h0000_0300);
    tick(1); clr(); tick(16);

    // IF exception beats mret
    c0 = cyc;
    if_v = 1; if_c = 4'd1; if_pc = 32'h10; mret_req = 1;
    expect_all(c0, 0, 32'h10, 32'h1, 32'h0000_0300);
    tick(1); clr(); tick(16);

    // mret beats a pending external interrupt, which is taken back-to-back
    tvec = 32'h0000_0240; mepc = 32'h0000_0400;
    c0 = cyc;
    mret_req = 1; irq_ext = 1; mie = 32'h0000_0800; mie_g = 1; irq_pc_v = 1; irq_pc = 32'h60;
    for (int g = 0; g < 3; g++) begin
      expect_seq(g, c0, 1, '0, '0, 32'h0000_0400, 1'b1);
      expect_seq(g, c0 + 3 + fc(g), 0, 32'h60, 32'h8000_000B, 32'h0000_0240, 1'b1);
    end
    tick(1); mret_req = 0; tick(7); clr(); tick(16);

    // Timer + soft enabled: soft wins
    c0 = cyc;
    irq_timer = 1; irq_soft = 1; mie = 32'h0000_0088; mie_g = 1; irq_pc_v = 1; irq_pc = 32'h50;
    expect_all(c0, 0, 32'h50, 32'h8000_0003, 32'h0000_0240);
    tick(1); clr(); tick(16);

    // Ext + timer enabled: ext wins
    c0 = cyc;
    irq_ext = 1; irq_timer = 1; mie = 32'h0000_0880; mie_g = 1; irq_pc_v = 1; irq_pc = 32'h54;
    expect_all(c0, 0, 32'h54, 32'h8000_000B, 32'h0000_0240);
    tick(1); clr(); tick(16);

    // All lines high, only timer enabled
    c0 = cyc;
    irq_ext = 1; irq_soft = 1; irq_timer = 1; mie = 32'h0000_0080; mie_g = 1;
    irq_pc_v = 1; irq_pc = 32'h58;
    expect_all(c0, 0, 32'h58, 32'h8000_0007, 32'h0000_0240);
    tick(1); clr(); tick(16);

    // Global enable low: no trap
    irq_timer = 1; irq_soft = 1; mie = 32'h0000_0088; mie_g = 0; irq_pc_v = 1; irq_pc = 32'h50;
    tick(3); clr(); tick(4);

    // No interruptible instruction: no trap
    irq_timer = 1; irq_soft = 1; mie = 32'h0000_0088; mie_g = 1; irq_pc_v = 0; irq_pc = 32'h50;
    tick(3); clr(); tick(4);

    // Request during DRAIN is ignored
    c0 = cyc;
    mem_v = 1; mem_c = 4'd5; mem_pc = 32'h180;
    expect_all(c0, 0, 32'h180, 32'h5, 32'h0000_0240);
    tick(1); clr(); tick(1);
    id_v = 1; id_c = 4'd2; id_pc = 32'h1C0;
    tick(1); clr(); tick(16);

    // Reset during DRAIN abandons the sequence
    c0 = cyc;
    mem_v = 1; mem_c = 4'd7; mem_pc = 32'h1F0;
    for (int g = 0; g < 3; g++) expect_seq(g, c0, 0, 32'h1F0, 32'h7, '0, 1'b0);
    tick(1); clr(); tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_zero("reset_mid");
    tick(10);

    for (int g = 0; g < 3; g++) begin
      checks++;
      if (exp_q[g].size() != 0) begin
        failures++;
        $display("FAIL missing_events dut%0d: %0d pending, required 0", g, exp_q[g].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
